// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, drives the combinational imem and
// registers each fetched word (plus any fetch fault) into a one-entry
// valid/ready stage for decode. A captured fault parks the unit in HALT
// until a redirect supplies a new PC.
module ifetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] pc_addr,
    input  logic [31:0] instruction,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_exc_en,
    output logic [3:0]  if_exc_code,
    output logic [63:0] if_exc_val,
    output logic [63:0] fetch_count
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  r_state;
    logic [63:0] r_pc;
    logic        r_valid;
    logic [63:0] r_if_pc;
    logic [31:0] r_instr;
    logic        r_exc_en;
    logic [3:0]  r_exc_code;
    logic [63:0] r_exc_val;
    logic [63:0] r_fetch_count;

    logic        w_capture;
    logic        w_misaligned;
    logic        w_handoff;

    // A capture needs a free (or draining) output slot; redirect always
    // preempts it so a stale fetch never reaches decode.
    assign w_capture    = (r_state == ST_RUN) && !redirect_en && (!r_valid || if_ready);
    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign w_handoff    = r_valid && if_ready;

    assign pc_addr     = r_pc;
    assign if_valid    = r_valid;
    assign if_pc       = r_if_pc;
    assign if_instr    = r_instr;
    assign if_exc_en   = r_exc_en;
    assign if_exc_code = r_exc_code;
    assign if_exc_val  = r_exc_val;
    assign fetch_count = r_fetch_count;

    // PC, state machine and output stage: redirect > capture > drain/hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_if_pc    <= 64'd0;
            r_instr    <= NOP_INSN;
            r_exc_en   <= 1'b0;
            r_exc_code <= 4'd0;
            r_exc_val  <= 64'd0;
        end else if (redirect_en) begin
            r_state <= ST_RUN;
            r_pc    <= redirect_pc;
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_if_pc <= r_pc;
            if (w_misaligned) begin
                r_instr    <= NOP_INSN;
                r_exc_en   <= 1'b1;
                r_exc_code <= 4'd0;
                r_exc_val  <= r_pc;
                r_state    <= ST_HALT;
            end else if (imem_exc_en) begin
                r_instr    <= NOP_INSN;
                r_exc_en   <= 1'b1;
                r_exc_code <= imem_exc_code;
                r_exc_val  <= imem_exc_val;
                r_state    <= ST_HALT;
            end else begin
                r_instr    <= instruction;
                r_exc_en   <= 1'b0;
                r_exc_code <= 4'd0;
                r_exc_val  <= 64'd0;
                r_pc       <= r_pc + 64'd4;
            end
        end else begin
            if (r_state == ST_BOOT) r_state <= ST_RUN;
            if (if_ready) r_valid <= 1'b0;
        end
    end

    // Handoff counter; a handoff in a redirect cycle still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fetch_count <= 64'd0;
        else if (w_handoff) r_fetch_count <= r_fetch_count + 64'd1;
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the fetch rules.
module tb_ifetch;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc_addr;
    logic [31:0] instruction;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_en = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_exc_en;
    logic [3:0]  if_exc_code;
    logic [63:0] if_exc_val;
    logic [63:0] fetch_count;

    // imem behaviour controls
    logic        fault_on   = 1'b0;
    logic [63:0] fault_addr = 64'd0;
    logic [3:0]  fault_code = 4'd1;
    logic        exc_noise  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(RST_PC), .NOP_INSN(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .instruction(instruction),
        .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .if_exc_en(if_exc_en), .if_exc_code(if_exc_code), .if_exc_val(if_exc_val),
        .fetch_count(fetch_count)
    );

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        if (a == RST_PC) return 32'h0050_0093;
        return {a[31:2], 2'b11} ^ 32'h0F0F_0000;
    endfunction

    function automatic logic fault_at(input logic [63:0] a);
        return (fault_on && a == fault_addr) || exc_noise;
    endfunction

    assign instruction   = instr_of(pc_addr);
    assign imem_exc_en   = fault_at(pc_addr);
    assign imem_exc_code = fault_code;
    assign imem_exc_val  = pc_addr;

    // ---------------- reference model ----------------
    logic        m_boot, m_halt, m_valid, m_exc;
    logic [63:0] m_pc, m_epc, m_eval, m_cnt;
    logic [31:0] m_instr;
    logic [3:0]  m_code;

    task automatic model_reset();
        m_boot = 1; m_halt = 0; m_valid = 0; m_pc = RST_PC;
        m_epc = 0; m_instr = NOP; m_exc = 0; m_code = 0; m_eval = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic rdy, input logic rdr, input logic [63:0] rpc);
        logic free_slot;
        free_slot = !m_valid || rdy;
        if (m_valid && rdy) m_cnt = m_cnt + 1;
        if (rdr) begin
            m_valid = 0; m_pc = rpc; m_boot = 0; m_halt = 0;
        end else if (!m_boot && !m_halt && free_slot) begin
            m_valid = 1; m_epc = m_pc;
            if (m_pc % 4 != 0) begin
                m_exc = 1; m_code = 0; m_eval = m_pc; m_instr = NOP; m_halt = 1;
            end else if (fault_at(m_pc)) begin
                m_exc = 1; m_code = fault_code; m_eval = m_pc; m_instr = NOP; m_halt = 1;
            end else begin
                m_exc = 0; m_code = 0; m_eval = 0; m_instr = instr_of(m_pc); m_pc = m_pc + 4;
            end
        end else begin
            m_boot = 0;
            if (rdy) m_valid = 0;
        end
    endtask

    logic [293:0] dut_vec;
    assign dut_vec = {pc_addr, if_valid, if_pc, if_instr, if_exc_en, if_exc_code, if_exc_val, fetch_count};

    function automatic logic [293:0] exp_vec();
        return {m_pc, m_valid, m_epc, m_instr, m_exc, m_code, m_eval, m_cnt};
    endfunction

    // One clock: drive inputs at the falling edge, step the model, sample at the next falling edge.
    task automatic cyc(input logic rdy, input logic rdr, input logic [63:0] rpc);
        if_ready = rdy; redirect_en = rdr; redirect_pc = rpc;
        model_step(rdy, rdr, rpc);
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        @(negedge clk);
        n_tests++;
        if (pc_addr !== RST_PC || if_valid !== 1'b0 || if_pc !== 64'd0 || if_instr !== NOP ||
            if_exc_en !== 1'b0 || if_exc_code !== 4'd0 || if_exc_val !== 64'd0 || fetch_count !== 64'd0) begin
            n_fail++; $display("FAIL reset_values got %h", dut_vec);
        end
        rst_n = 1'b1;
        cyc(1, 0, 0);
        n_tests++;
        if (if_valid !== 1'b0 || pc_addr !== RST_PC) begin
            n_fail++; $display("FAIL boot_cycle valid=%b pc_addr=%h want 0 %h", if_valid, pc_addr, RST_PC);
        end
        cyc(1, 0, 0);
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== RST_PC || if_instr !== 32'h0050_0093 || pc_addr !== RST_PC + 4) begin
            n_fail++; $display("FAIL first_fetch valid=%b pc=%h instr=%h pc_addr=%h", if_valid, if_pc, if_instr, pc_addr);
        end
    endtask

    task automatic test_stall();
        logic [293:0] snap;
        logic [63:0]  spc, cnt0;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        snap = exp_vec(); spc = m_epc; cnt0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            exc_noise = (i % 2 == 0);
            cyc(0, 0, 0);
            n_tests++;
            if (dut_vec !== snap) begin
                n_fail++; $display("FAIL stall_hold[%0d] got %h want %h", i, dut_vec, snap);
            end
        end
        exc_noise = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc(1, 0, 0);
            n_tests++;
            if (if_valid !== 1'b1 || if_pc !== spc + 64'(4 * k) || if_exc_en !== 1'b0) begin
                n_fail++; $display("FAIL stall_release[%0d] valid=%b pc=%h want pc %h", k, if_valid, if_pc, spc + 64'(4 * k));
            end
        end
        n_tests++;
        if (fetch_count !== cnt0 + 4) begin
            n_fail++; $display("FAIL stall_count got %0d want %0d", fetch_count, cnt0 + 4);
        end
    endtask

    task automatic test_redirect();
        cyc(0, 0, 0);
        cyc(0, 1, 64'h8000_0100);
        n_tests++;
        if (if_valid !== 1'b0 || pc_addr !== 64'h8000_0100) begin
            n_fail++; $display("FAIL redirect_flush valid=%b pc_addr=%h want 0 80000100", if_valid, pc_addr);
        end
        cyc(1, 0, 0);
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 64'h8000_0100 || if_instr !== instr_of(64'h8000_0100)) begin
            n_fail++; $display("FAIL redirect_target valid=%b pc=%h instr=%h", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_misaligned();
        cyc(1, 1, 64'h8000_0102);
        cyc(1, 0, 0);
        n_tests++;
        if (if_valid !== 1'b1 || if_exc_en !== 1'b1 || if_exc_code !== 4'd0 ||
            if_exc_val !== 64'h8000_0102 || if_instr !== NOP || if_pc !== 64'h8000_0102) begin
            n_fail++; $display("FAIL misaligned_entry v=%b e=%b c=%h val=%h instr=%h", if_valid, if_exc_en, if_exc_code, if_exc_val, if_instr);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            n_tests++;
            if (if_valid !== 1'b0 || pc_addr !== 64'h8000_0102) begin
                n_fail++; $display("FAIL misaligned_halt[%0d] valid=%b pc_addr=%h", i, if_valid, pc_addr);
            end
        end
    endtask

    task automatic test_imem_fault();
        fault_on = 1'b1; fault_addr = 64'h8004_0000; fault_code = 4'd1;
        cyc(1, 1, 64'h8004_0000);
        cyc(1, 0, 0);
        n_tests++;
        if (if_valid !== 1'b1 || if_exc_en !== 1'b1 || if_exc_code !== 4'd1 ||
            if_exc_val !== 64'h8004_0000 || if_instr !== NOP) begin
            n_fail++; $display("FAIL imem_fault_entry v=%b e=%b c=%h val=%h instr=%h", if_valid, if_exc_en, if_exc_code, if_exc_val, if_instr);
        end
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        n_tests++;
        if (if_valid !== 1'b0) begin
            n_fail++; $display("FAIL imem_fault_halt valid=%b want 0", if_valid);
        end
        cyc(1, 1, RST_PC);
        cyc(1, 0, 0);
        n_tests++;
        if (if_valid !== 1'b1 || if_exc_en !== 1'b0 || if_pc !== RST_PC || if_instr !== 32'h0050_0093) begin
            n_fail++; $display("FAIL fault_resume valid=%b exc=%b pc=%h", if_valid, if_exc_en, if_pc);
        end
        fault_on = 1'b0;
    endtask

    task automatic test_wrap();
        cyc(1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1, 0, 0);
        n_tests++;
        if (if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || pc_addr !== 64'd0 || if_exc_en !== 1'b0) begin
            n_fail++; $display("FAIL pc_wrap if_pc=%h pc_addr=%h", if_pc, pc_addr);
        end
    endtask

    task automatic test_random();
        logic        rdr;
        logic [63:0] tgt;
        fault_on = 1'b1; fault_addr = RST_PC + 64'h40; fault_code = 4'($urandom_range(1, 15));
        for (int i = 0; i < 400; i++) begin
            rdr = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 9))
                6:       tgt = RST_PC + 64'($urandom_range(1, 3));
                7:       tgt = fault_addr;
                8:       tgt = 64'hFFFF_FFFF_FFFF_FFF8;
                9:       tgt = RST_PC;
                default: tgt = RST_PC + 64'({$urandom_range(0, 31), 2'b00});
            endcase
            exc_noise = ($urandom_range(0, 99) < 4);
            cyc(logic'($urandom_range(0, 99) < 70), rdr, tgt);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random[%0d] got %h want %h", i, dut_vec, exp_vec());
            end
        end
        exc_noise = 1'b0; fault_on = 1'b0;
    endtask

    task automatic test_async_reset();
        cyc(1, 1, 64'h8000_0201);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (if_valid !== 1'b0 || pc_addr !== RST_PC || fetch_count !== 64'd0 || if_instr !== NOP) begin
            n_fail++; $display("FAIL async_reset valid=%b pc_addr=%h count=%0d", if_valid, pc_addr, fetch_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        n_tests++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL post_reset got %h want %h", dut_vec, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_misaligned();
        test_imem_fault();
        test_wrap();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
